trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 218 +++++++++++++++++++++
 tb/tb_trigger_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture with a blanking-synchronised copy into a display RAM.
// Optional auto-trigger after TIMEOUT armed cycles: define TRIGGER_TIMEOUT_EN.
module trigger_capture #(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 512,
    parameter int PRE_TRIG = 128,
    parameter int BLANK_H  = 600,
    parameter int BLANK_V  = 6,
    parameter int TIMEOUT  = 1048576
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    output logic                     ready,
    output logic                     triggered,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        sample,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic                     trig_edge,
    input  logic [10:0]              vcount,
    input  logic [10:0]              hcount,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int POST_N = DEPTH - PRE_TRIG;

    localparam logic [AW-1:0] PRE_A    = AW'(PRE_TRIG);
    localparam logic [AW-1:0] LAST_A   = AW'(DEPTH - 1);
    localparam logic [CW-1:0] PRE_END  = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] POST_END = CW'(POST_N - 1);
    localparam logic [10:0]   BH       = 11'(BLANK_H);
    localparam logic [10:0]   BV       = 11'(BLANK_V);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        WAIT_BLANK,
        COPY
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
    logic              triggered_q, triggered_d;
    logic [AW-1:0]     copy_q, copy_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] cap_mem  [DEPTH];
    logic [DATA_W-1:0] disp_mem [DEPTH];

    logic              cap_we;
    logic              disp_we;
    logic              edge_hit;
    logic              timeout_hit;
    logic [AW-1:0]     cap_rd_addr;

    assign ready       = (state_q == IDLE);
    assign triggered   = triggered_q;
    assign rd_data     = rd_data_q;
    assign cap_rd_addr = trig_ptr_q - PRE_A + copy_q;

    always_comb begin
        if (trig_edge) begin
            edge_hit = (prev_q >= trig_level) && (sample < trig_level);
        end else begin
            edge_hit = (prev_q < trig_level) && (sample >= trig_level);
        end
    end

`ifdef TRIGGER_TIMEOUT_EN
    // Saturating armed-cycle counter; zero whenever not armed.
    logic [31:0] to_q, to_d;

    assign timeout_hit = (state_q == ARMED) && (to_q == 32'(TIMEOUT));

    always_comb begin
        to_d = '0;
        if (state_q == ARMED) begin
            to_d = timeout_hit ? to_q : to_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        trig_ptr_d  = trig_ptr_q;
        triggered_d = triggered_q;
        copy_d      = copy_q;
        cap_we      = 1'b0;
        disp_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    wr_ptr_d    = '0;
                    cnt_d       = '0;
                    copy_d      = '0;
                    triggered_d = 1'b0;
                    state_d     = PRE;
                end
            end
            PRE: begin
                if (sample_valid) begin
                    cap_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample;
                    if (cnt_q == PRE_END) begin
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                if (sample_valid) begin
                    cap_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample;
                    if (edge_hit || timeout_hit) begin
                        trig_ptr_d  = wr_ptr_q;
                        triggered_d = edge_hit;
                        // The trigger sample is the first post-trigger sample.
                        cnt_d       = CW'(1);
                        state_d     = (POST_N == 1) ? WAIT_BLANK : POST;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    cap_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    prev_d   = sample;
                    if (cnt_q == POST_END) begin
                        cnt_d   = '0;
                        state_d = WAIT_BLANK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_BLANK: begin
                if ((hcount == BH) || (vcount < BV)) begin
                    copy_d  = '0;
                    state_d = COPY;
                end
            end
            COPY: begin
                disp_we = 1'b1;
                copy_d  = copy_q + 1'b1;
                if (copy_q == LAST_A) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            trig_ptr_q  <= '0;
            triggered_q <= 1'b0;
            copy_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            trig_ptr_q  <= trig_ptr_d;
            triggered_q <= triggered_d;
            copy_q      <= copy_d;
        end
    end

    // Capture RAM is read asynchronously so COPY moves one word per cycle.
    always_ff @(posedge clk) begin
        if (rst && cap_we) begin
            cap_mem[wr_ptr_q] <= sample;
        end
        if (rst && disp_we) begin
            disp_mem[copy_q] <= cap_mem[cap_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= disp_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: ramp, sawtooth, gated valid,
// blanking timing, reset abort and optional timeout.
module tb_trigger_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;

    logic              clk;
    logic              rst;
    logic              arm;
    logic              ready;
    logic              triggered;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic [10:0]       vcount;
    logic [10:0]       hcount;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    int   mode   = 0;
    int   gval   = 0;
    int   cval   = 0;
    logic tog_en = 1'b0;
    logic tog_ph = 1'b0;

    trigger_capture #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .PRE_TRIG(128),
        .BLANK_H (600),
        .BLANK_V (6),
        .TIMEOUT (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .ready       (ready),
        .triggered   (triggered),
        .sample_valid(sample_valid),
        .sample      (sample),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .vcount      (vcount),
        .hcount      (hcount),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then present the next stimulus word.
    task automatic tick();
        @(negedge clk);
        tog_ph       = tog_en ? ~tog_ph : 1'b1;
        sample_valid = tog_ph;
        if (sample_valid) begin
            case (mode)
                1:       sample = DATA_W'(gval);
                2:       sample = DATA_W'(gval % 256);
                default: sample = DATA_W'(cval);
            endcase
            gval++;
        end
    endtask

    task automatic do_arm();
        tick();
        arm  = 1'b1;
        gval = 0;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = ready;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_trig(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = triggered;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_disp(input string tag, input int a, input int exp);
        rd_addr = AW'(a);
        tick();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst          = 1'b0;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        trig_level   = 12'd300;
        trig_edge    = 1'b0;
        vcount       = 11'd0;
        hcount       = 11'd0;
        rd_addr      = '0;

        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_trig", 32'(triggered), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);
        rst = 1'b1;
        tick();

        // Ramp, rising through 300
        mode = 1;
        do_arm();
        chk("arm_ready_low", 32'(ready), 32'd0);
        wait_ready("ramp_done", 3000);
        chk("ramp_trig", 32'(triggered), 32'd1);
        chk_disp("ramp_d0", 0, 172);
        chk_disp("ramp_d127", 127, 299);
        chk_disp("ramp_d128", 128, 300);
        chk_disp("ramp_d340", 340, 512);
        chk_disp("ramp_d511", 511, 683);

        // Sawtooth, falling through 100
        mode       = 2;
        trig_level = 12'd100;
        trig_edge  = 1'b1;
        do_arm();
        wait_ready("saw_done", 3000);
        chk("saw_trig", 32'(triggered), 32'd1);
        chk_disp("saw_d0", 0, 128);
        chk_disp("saw_d127", 127, 255);
        chk_disp("saw_d128", 128, 0);
        chk_disp("saw_d511", 511, 127);

        // Gated valid plus a stray arm during POST
        mode       = 1;
        trig_level = 12'd300;
        trig_edge  = 1'b0;
        tog_en     = 1'b1;
        do_arm();
        wait_trig("tog_trig_seen", 3000);
        repeat (20) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("tog_arm_ign_rdy", 32'(ready), 32'd0);
        chk("tog_arm_ign_trg", 32'(triggered), 32'd1);
        wait_ready("tog_done", 3000);
        tog_en = 1'b0;
        chk_disp("tog_d0", 0, 172);
        chk_disp("tog_d128", 128, 300);
        chk_disp("tog_d511", 511, 683);

        // Copy window held closed, then opened by hcount
        vcount = 11'd100;
        hcount = 11'd0;
        do_arm();
        wait_trig("blank_trig_seen", 3000);
        repeat (450) tick();
        chk("blank_hold", 32'(ready), 32'd0);
        tick();
        hcount = 11'd600;
        repeat (512) tick();
        chk("blank_512", 32'(ready), 32'd0);
        tick();
        chk("blank_513", 32'(ready), 32'd1);
        vcount = 11'd0;
        hcount = 11'd0;
        chk_disp("blank_d128", 128, 300);

        // Reset during POST aborts the capture
        rd_addr = AW'(128);
        do_arm();
        wait_trig("rpost_trig_seen", 3000);
        repeat (10) tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rpost_ready", 32'(ready), 32'd1);
        chk("rpost_trig", 32'(triggered), 32'd0);
        chk("rpost_rdata", 32'(rd_data), 32'd0);
        rst = 1'b1;
        tick();
        do_arm();
        wait_ready("rearm_done", 3000);
        chk("rearm_trig", 32'(triggered), 32'd1);
        chk_disp("rearm_d128", 128, 300);

        // Constant input never crosses the level
        mode = 0;
        cval = 50;
`ifdef TRIGGER_TIMEOUT_EN
        do_arm();
        wait_ready("to_done", 5000);
        chk("to_trig", 32'(triggered), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            chk_disp("to_word", a, 50);
        end
`else
        do_arm();
        repeat (3000) tick();
        chk("noto_wait", 32'(ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("noto_rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
